// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller:
// FSM states, ALU operation codes, opcodes, immediate formats and mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_FAULT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctrl_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_REG   = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Everything the controller drives toward the datapath, except ImmSrc.
  typedef struct packed {
    logic      pc_write;
    logic      ir_write;
    logic      adr_src;
    logic      mem_write;
    logic      reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_ctrl_e alu_control;
    logic      fault;
  } ctrl_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction/status in, enables and selects out.
interface multicycle_controller_if;

  logic [31:0] Instr;
  logic        Zero;
  logic        MemReady;

  logic        PCWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;
  logic        Fault;

  modport master (
    input  Instr, Zero, MemReady,
    output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Fault
  );

  modport slave (
    output Instr, Zero, MemReady,
    input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Fault
  );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode for register and immediate arithmetic instructions.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output alu_ctrl_e  alu_control_c
);

  always_comb begin
    alu_control_c = ALU_ADD;
    case (funct3)
      // Only register-register form can encode subtract; addi ignores bit 30.
      3'b000:  alu_control_c = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control_c = ALU_SLL;
      3'b010:  alu_control_c = ALU_SLT;
      3'b100:  alu_control_c = ALU_XOR;
      3'b101:  alu_control_c = ALU_SRL;
      3'b110:  alu_control_c = ALU_OR;
      3'b111:  alu_control_c = ALU_AND;
      default: alu_control_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with a bounded memory-wait counter and a
// sticky FAULT state for unknown opcodes or memory timeouts.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_controller_if.master bus
);

  localparam int unsigned CNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             wait_expired;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  alu_ctrl_e        dec_alu;
  ctrl_t            ctrl;
  logic             unused_instr_bits;

  assign op       = bus.Instr[6:0];
  assign funct3   = bus.Instr[14:12];
  assign funct7b5 = bus.Instr[30];
  assign unused_instr_bits = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

  alu_decoder u_alu_decoder (
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .is_rtype      (state_q == S_EXECR),
    .alu_control_c (dec_alu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state; the wait counter only survives while a memory state keeps waiting.
  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    wait_expired = (wait_q == CNT_W'(MEM_WAIT_MAX));
    case (state_q)
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (bus.MemReady) begin
          case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_MEMREAD: state_d = S_MEMWB;
            default:   state_d = S_FETCH;
          endcase
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LOAD)       state_d = S_MEMREAD;
        else if (op == OP_STORE) state_d = S_MEMWRITE;
        else                     state_d = S_FAULT;
      end
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:    state_d = S_ALUWB;
      S_FAULT:                    state_d = S_FAULT;
      default:                    state_d = S_FAULT;
    endcase
  end

  // Moore decode; FETCH and BRANCH also qualify PCWrite on MemReady / Zero.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.pc_write   = bus.MemReady;
        ctrl.ir_write   = bus.MemReady;
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a   = SRC_A_REG;
        ctrl.alu_src_b   = SRC_B_REG;
        ctrl.alu_control = dec_alu;
      end
      S_EXECI: begin
        ctrl.alu_src_a   = SRC_A_REG;
        ctrl.alu_src_b   = SRC_B_IMM;
        ctrl.alu_control = dec_alu;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = SRC_A_REG;
        ctrl.alu_src_b   = SRC_B_REG;
        ctrl.alu_control = ALU_SUB;
        ctrl.result_src  = RES_ALUOUT;
        ctrl.pc_write    = bus.Zero ^ funct3[0];
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRC_A_OLDPC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      S_FAULT: ctrl.fault = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // Enables are masked while reset is held so an aborted access writes nothing.
  assign bus.PCWrite    = ctrl.pc_write  & rst_n;
  assign bus.IRWrite    = ctrl.ir_write  & rst_n;
  assign bus.MemWrite   = ctrl.mem_write & rst_n;
  assign bus.RegWrite   = ctrl.reg_write & rst_n;
  assign bus.AdrSrc     = ctrl.adr_src;
  assign bus.ResultSrc  = ctrl.result_src;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUControl = ctrl.alu_control;
  assign bus.Fault      = ctrl.fault;
  assign bus.ImmSrc     = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table plus
// hand-written timeout, reset-abort and bad-opcode sequences.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw, irw, adr, mw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    logic       flt;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    logic        rdy;
    obs_t        exp;
  } vec_t;

  localparam logic [31:0] LW   = 32'h0000_2003;
  localparam logic [31:0] SW   = 32'h0000_2023;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] BNE  = 32'h0000_1063;
  localparam logic [31:0] ADD  = 32'h0000_0033;
  localparam logic [31:0] SUB  = 32'h4000_0033;
  localparam logic [31:0] ADDI = 32'h4000_0013;
  localparam logic [31:0] XORR = 32'h0000_4033;
  localparam logic [31:0] ORI  = 32'h0000_6013;
  localparam logic [31:0] ANDR = 32'h0000_7033;
  localparam logic [31:0] SLTR = 32'h0000_2033;
  localparam logic [31:0] SLLI = 32'h0000_1013;
  localparam logic [31:0] SRLR = 32'h4000_5033;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] BAD  = 32'h0000_007F;

  localparam logic [1:0] IL = 2'b00, IS = 2'b01, IB = 2'b10, IJ = 2'b11;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  vec_t vecs[$];
  obs_t sb_q[$];

  multicycle_controller_if bus ();

  multicycle_controller #(.MEM_WAIT_MAX(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t mk(input logic pcw, input logic irw, input logic adr,
                              input logic mw, input logic rw, input logic [1:0] rs,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [1:0] imm, input logic [2:0] alu,
                              input logic flt);
    return {pcw, irw, adr, mw, rw, rs, sa, sb, imm, alu, flt};
  endfunction

  // Expected outputs of each state, straight from the state descriptions.
  function automatic obs_t e_fetch(input logic [1:0] imm, input logic rdy);
    return mk(rdy, rdy, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
  endfunction
  function automatic obs_t e_decode(input logic [1:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 1'b0);
  endfunction
  function automatic obs_t e_memadr(input logic [1:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 1'b0);
  endfunction
  function automatic obs_t e_memrd(input logic [1:0] imm);
    return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic obs_t e_memwr(input logic [1:0] imm);
    return mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic obs_t e_memwb(input logic [1:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic obs_t e_exec(input logic [1:0] imm, input logic is_i, input logic [2:0] alu);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, is_i ? 2'b01 : 2'b00, imm, alu, 1'b0);
  endfunction
  function automatic obs_t e_aluwb(input logic [1:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0);
  endfunction
  function automatic obs_t e_branch(input logic [1:0] imm, input logic pcw);
    return mk(pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, 3'b001, 1'b0);
  endfunction
  function automatic obs_t e_jal(input logic [1:0] imm);
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 1'b0);
  endfunction
  function automatic obs_t e_fault(input logic [1:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b1);
  endfunction

  function automatic obs_t sample();
    return {bus.PCWrite, bus.IRWrite, bus.AdrSrc, bus.MemWrite, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.Fault};
  endfunction

  task automatic add(input string n, input logic [31:0] i, input logic z, input logic r,
                     input obs_t e);
    vec_t v;
    v.name = n; v.instr = i; v.zero = z; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endtask

  // Queue the expectation, let the outputs settle, then pop and compare.
  task automatic check_now(input string n, input obs_t e);
    obs_t want, got;
    sb_q.push_back(e);
    #1;
    got  = sample();
    want = sb_q.pop_front();
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (pcw irw adr mw rw rs sa sb imm alu flt)",
               n, got, want);
    end
  endtask

  task automatic step(input string n, input logic [31:0] i, input logic z, input logic r,
                      input obs_t e);
    bus.Instr    = i;
    bus.Zero     = z;
    bus.MemReady = r;
    check_now(n, e);
    @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n        = 1'b0;
    bus.Instr    = LW;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b0;

    add("lw.fetch",   LW, 1'b0, 1'b1, e_fetch(IL, 1'b1));
    add("lw.decode",  LW, 1'b0, 1'b1, e_decode(IL));
    add("lw.memadr",  LW, 1'b0, 1'b1, e_memadr(IL));
    add("lw.memread", LW, 1'b0, 1'b1, e_memrd(IL));
    add("lw.memwb",   LW, 1'b0, 1'b1, e_memwb(IL));
    add("sw.fetch",   SW, 1'b0, 1'b1, e_fetch(IS, 1'b1));
    add("sw.decode",  SW, 1'b1, 1'b0, e_decode(IS));
    add("sw.memadr",  SW, 1'b1, 1'b0, e_memadr(IS));
    for (int k = 0; k < 3; k++) add("sw.memwr_wait", SW, 1'b0, 1'b0, e_memwr(IS));
    add("sw.memwr_done", SW, 1'b0, 1'b1, e_memwr(IS));
    add("beq_z1.fetch",  BEQ, 1'b1, 1'b1, e_fetch(IB, 1'b1));
    add("beq_z1.decode", BEQ, 1'b1, 1'b0, e_decode(IB));
    add("beq_z1.branch", BEQ, 1'b1, 1'b0, e_branch(IB, 1'b1));
    add("bne_z1.fetch",  BNE, 1'b1, 1'b1, e_fetch(IB, 1'b1));
    add("bne_z1.decode", BNE, 1'b1, 1'b0, e_decode(IB));
    add("bne_z1.branch", BNE, 1'b1, 1'b1, e_branch(IB, 1'b0));
    add("beq_z0.fetch",  BEQ, 1'b0, 1'b1, e_fetch(IB, 1'b1));
    add("beq_z0.decode", BEQ, 1'b0, 1'b0, e_decode(IB));
    add("beq_z0.branch", BEQ, 1'b0, 1'b1, e_branch(IB, 1'b0));
    add("bne_z0.fetch",  BNE, 1'b0, 1'b1, e_fetch(IB, 1'b1));
    add("bne_z0.decode", BNE, 1'b0, 1'b0, e_decode(IB));
    add("bne_z0.branch", BNE, 1'b0, 1'b0, e_branch(IB, 1'b1));
    add("sub.fetch",   SUB,  1'b0, 1'b1, e_fetch(IL, 1'b1));
    add("sub.decode",  SUB,  1'b0, 1'b0, e_decode(IL));
    add("sub.execr",   SUB,  1'b1, 1'b0, e_exec(IL, 1'b0, 3'b001));
    add("sub.aluwb",   SUB,  1'b0, 1'b0, e_aluwb(IL));
    add("addi.fetch",  ADDI, 1'b0, 1'b1, e_fetch(IL, 1'b1));
    add("addi.decode", ADDI, 1'b0, 1'b0, e_decode(IL));
    add("addi.execi",  ADDI, 1'b1, 1'b1, e_exec(IL, 1'b1, 3'b000));
    add("addi.aluwb",  ADDI, 1'b0, 1'b0, e_aluwb(IL));
    add("xor.fetch",   XORR, 1'b0, 1'b1, e_fetch(IL, 1'b1));
    add("xor.decode",  XORR, 1'b0, 1'b0, e_decode(IL));
    add("xor.execr",   XORR, 1'b0, 1'b0, e_exec(IL, 1'b0, 3'b100));
    add("xor.aluwb",   XORR, 1'b0, 1'b0, e_aluwb(IL));
    add("ori.fetch",   ORI,  1'b0, 1'b1, e_fetch(IL, 1'b1));
    add("ori.decode",  ORI,  1'b0, 1'b0, e_decode(IL));
    add("ori.execi",   ORI,  1'b0, 1'b0, e_exec(IL, 1'b1, 3'b011));
    add("ori.aluwb",   ORI,  1'b0, 1'b0, e_aluwb(IL));
    add("and.fetch",   ANDR, 1'b0, 1'b1, e_fetch(IL, 1'b1));
    add("and.decode",  ANDR, 1'b0, 1'b0, e_decode(IL));
    add("and.execr",   ANDR, 1'b0, 1'b0, e_exec(IL, 1'b0, 3'b010));
    add("and.aluwb",   ANDR, 1'b0, 1'b0, e_aluwb(IL));
    add("slt.fetch",   SLTR, 1'b0, 1'b1, e_fetch(IL, 1'b1));
    add("slt.decode",  SLTR, 1'b0, 1'b0, e_decode(IL));
    add("slt.execr",   SLTR, 1'b0, 1'b0, e_exec(IL, 1'b0, 3'b101));
    add("slt.aluwb",   SLTR, 1'b0, 1'b0, e_aluwb(IL));
    add("slli.fetch",  SLLI, 1'b0, 1'b1, e_fetch(IL, 1'b1));
    add("slli.decode", SLLI, 1'b0, 1'b0, e_decode(IL));
    add("slli.execi",  SLLI, 1'b0, 1'b0, e_exec(IL, 1'b1, 3'b110));
    add("slli.aluwb",  SLLI, 1'b0, 1'b0, e_aluwb(IL));
    add("srl.fetch",   SRLR, 1'b0, 1'b1, e_fetch(IL, 1'b1));
    add("srl.decode",  SRLR, 1'b0, 1'b0, e_decode(IL));
    add("srl.execr",   SRLR, 1'b0, 1'b0, e_exec(IL, 1'b0, 3'b111));
    add("srl.aluwb",   SRLR, 1'b0, 1'b0, e_aluwb(IL));
    add("jal.fetch",   JAL,  1'b0, 1'b1, e_fetch(IJ, 1'b1));
    add("jal.decode",  JAL,  1'b0, 1'b0, e_decode(IJ));
    add("jal.jal",     JAL,  1'b1, 1'b0, e_jal(IJ));
    add("jal.aluwb",   JAL,  1'b0, 1'b0, e_aluwb(IJ));

    // Reset state: FETCH selects, enables held low even with MemReady high.
    repeat (2) @(negedge clk);
    step("reset.state", LW, 1'b0, 1'b1, e_fetch(IL, 1'b0));
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++)
      step(vecs[k].name, vecs[k].instr, vecs[k].zero, vecs[k].rdy, vecs[k].exp);

    // Counter restarts on each memory state: long FETCH wait, then a 15-cycle MEMREAD wait.
    for (int k = 0; k < 10; k++) step("cnt.fetch_wait", LW, 1'b0, 1'b0, e_fetch(IL, 1'b0));
    step("cnt.fetch_done", LW, 1'b0, 1'b1, e_fetch(IL, 1'b1));
    step("cnt.decode", LW, 1'b0, 1'b0, e_decode(IL));
    step("cnt.memadr", LW, 1'b0, 1'b0, e_memadr(IL));
    for (int k = 0; k < 15; k++) step("cnt.memrd_wait", LW, 1'b0, 1'b0, e_memrd(IL));
    step("cnt.memrd_limit_ready", LW, 1'b0, 1'b1, e_memrd(IL));
    step("cnt.memwb", LW, 1'b0, 1'b0, e_memwb(IL));

    // MemReady arriving exactly at the limit completes normally.
    for (int k = 0; k < 15; k++) step("lim.fetch_wait", ADD, 1'b0, 1'b0, e_fetch(IL, 1'b0));
    step("lim.fetch_ready", ADD, 1'b0, 1'b1, e_fetch(IL, 1'b1));
    step("lim.decode", ADD, 1'b0, 1'b0, e_decode(IL));
    step("lim.execr", ADD, 1'b0, 1'b0, e_exec(IL, 1'b0, 3'b000));
    step("lim.aluwb", ADD, 1'b0, 1'b0, e_aluwb(IL));

    // Asynchronous reset in the middle of a stalled store.
    step("rst.sw_fetch", SW, 1'b0, 1'b1, e_fetch(IS, 1'b1));
    step("rst.sw_decode", SW, 1'b0, 1'b0, e_decode(IS));
    step("rst.sw_memadr", SW, 1'b0, 1'b0, e_memadr(IS));
    step("rst.sw_memwr", SW, 1'b0, 1'b0, e_memwr(IS));
    check_now("rst.memwr_before", e_memwr(IS));
    #2;
    rst_n = 1'b0;
    check_now("rst.memwr_dropped", e_fetch(IS, 1'b0));
    @(negedge clk);
    step("rst.hold_ready", SW, 1'b0, 1'b1, e_fetch(IS, 1'b0));
    rst_n = 1'b1;
    step("rst.first_fetch", SW, 1'b0, 1'b1, e_fetch(IS, 1'b1));
    step("rst.decode", SW, 1'b0, 1'b0, e_decode(IS));
    step("rst.memadr", SW, 1'b0, 1'b0, e_memadr(IS));
    step("rst.memwr", SW, 1'b0, 1'b1, e_memwr(IS));

    // FETCH timeout after 16 idle cycles, then FAULT ignores all inputs.
    for (int k = 0; k < 16; k++) step("to.fetch_wait", LW, 1'b0, 1'b0, e_fetch(IL, 1'b0));
    for (int k = 0; k < 3; k++) step("to.fault_sticky", LW, 1'b1, 1'b1, e_fault(IL));

    rst_n = 1'b0;
    step("to.reset_clears", LW, 1'b0, 1'b1, e_fetch(IL, 1'b0));
    rst_n = 1'b1;

    // Unknown opcode faults straight out of DECODE.
    step("bad.fetch", BAD, 1'b0, 1'b1, e_fetch(IL, 1'b1));
    step("bad.decode", BAD, 1'b0, 1'b1, e_decode(IL));
    step("bad.fault", BAD, 1'b0, 1'b1, e_fault(IL));
    step("bad.fault_hold", ADD, 1'b1, 1'b1, e_fault(IL));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
